// File: rtl/game_sequencer.sv
// Game-phase controller: sequences idle, countdown, play, hit-freeze, pause and end states,
// tracks lives and gates the gameplay tick.
module game_sequencer #(
    parameter int unsigned LIVES_INIT       = 3,
    parameter int unsigned COUNTDOWN_TICKS  = 60,
    parameter int unsigned HIT_FREEZE_TICKS = 30,
    parameter logic [7:0]  WIN_LEVEL        = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic       start_n,
    input  logic       pause_sw,
    input  logic       collision,
    input  logic [7:0] bank_level,
    output logic       play_en,
    output logic       sub_rst,
    output logic [2:0] state,
    output logic [2:0] lives,
    output logic       flash
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_HIT       = 3'd3,
        S_PAUSE     = 3'd4,
        S_GAME_OVER = 3'd5,
        S_WIN       = 3'd6
    } state_t;

    state_t     cur_state, next_state;
    logic [2:0] lives_d;
    logic [7:0] timer, timer_d;
    logic       sub_rst_d, flash_d;
    logic       start_q, coll_q;
    logic       start_press, hit;

    assign start_press = start_q & ~start_n;
    assign hit         = collision & ~coll_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            lives     <= 3'(LIVES_INIT);
            timer     <= '0;
            sub_rst   <= 1'b0;
            flash     <= 1'b0;
            start_q   <= 1'b1;
            coll_q    <= 1'b0;
        end else begin
            cur_state <= next_state;
            lives     <= lives_d;
            timer     <= timer_d;
            sub_rst   <= sub_rst_d;
            flash     <= flash_d;
            start_q   <= start_n;
            coll_q    <= collision;
        end
    end

    always_comb begin
        next_state = cur_state;
        lives_d    = lives;
        timer_d    = timer;
        sub_rst_d  = 1'b0;
        case (cur_state)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (start_press) begin
                    next_state = S_COUNTDOWN;
                    timer_d    = 8'(COUNTDOWN_TICKS);
                    lives_d    = 3'(LIVES_INIT);
                    sub_rst_d  = 1'b1;
                end
            end
            S_COUNTDOWN, S_HIT: begin
                // Exit on the tick that would take the timer from 1 to 0, so it never wraps.
                if (game_en) begin
                    timer_d = timer - 8'd1;
                    if (timer == 8'd1) next_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (hit && lives == 3'd1) begin
                    next_state = S_GAME_OVER;
                    lives_d    = '0;
                end else if (hit) begin
                    next_state = S_HIT;
                    lives_d    = lives - 3'd1;
                    timer_d    = 8'(HIT_FREEZE_TICKS);
                end else if (bank_level >= WIN_LEVEL) begin
                    next_state = S_WIN;
                end else if (pause_sw) begin
                    next_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!pause_sw) next_state = S_PLAY;
            end
            default: next_state = S_IDLE;
        endcase

        // Flash is registered from the upcoming state/timer so it lines up with them.
        case (next_state)
            S_COUNTDOWN: flash_d = timer_d[3];
            S_HIT:       flash_d = timer_d[1];
            S_GAME_OVER: flash_d = 1'b1;
            default:     flash_d = 1'b0;
        endcase
    end

    assign state   = cur_state;
    assign play_en = game_en & (cur_state == S_PLAY) & ~pause_sw;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer with directed test-plan scenarios, checked every cycle
// against a rule-level reference model.
module tb_game_sequencer;

    localparam int unsigned P_LIVES = 3;
    localparam int unsigned P_CD    = 4;
    localparam int unsigned P_HF    = 3;
    localparam int unsigned P_WIN   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_en = 1'b0;
    logic       start_n = 1'b1;
    logic       pause_sw = 1'b0;
    logic       collision = 1'b0;
    logic [7:0] bank_level = '0;
    logic       play_en, sub_rst, flash;
    logic [2:0] state, lives;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned gcnt = 0;

    // Staged inputs, copied onto the DUT pins at the falling edge.
    logic       s_rst = 1'b1, s_start_n = 1'b1, s_pause = 1'b0, s_coll = 1'b0;
    logic [7:0] s_bank = '0;

    // Reference model state: phase numbers follow the documented state codes.
    int m_state = 0, m_lives = P_LIVES, m_ticks = 0;
    bit m_sub = 0, m_start_q = 1, m_coll_q = 0;

    game_sequencer #(
        .LIVES_INIT(P_LIVES),
        .COUNTDOWN_TICKS(P_CD),
        .HIT_FREEZE_TICKS(P_HF),
        .WIN_LEVEL(8'(P_WIN))
    ) dut (
        .clk(clk), .rst(rst), .game_en(game_en), .start_n(start_n),
        .pause_sw(pause_sw), .collision(collision), .bank_level(bank_level),
        .play_en(play_en), .sub_rst(sub_rst), .state(state), .lives(lives), .flash(flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_flash();
        if (m_state == 1) return (m_ticks >> 3) & 1;
        if (m_state == 3) return (m_ticks >> 1) & 1;
        if (m_state == 5) return 1;
        return 0;
    endfunction

    task automatic model_step();
        bit press, hit;
        if (rst) begin
            m_state = 0; m_lives = P_LIVES; m_ticks = 0;
            m_sub = 0; m_start_q = 1; m_coll_q = 0;
            return;
        end
        press = m_start_q && !start_n;
        hit   = collision && !m_coll_q;
        m_sub = 0;
        if ((m_state == 0 || m_state == 5 || m_state == 6) && press) begin
            m_state = 1; m_ticks = P_CD; m_lives = P_LIVES; m_sub = 1;
        end else if ((m_state == 1 || m_state == 3) && game_en) begin
            if (m_ticks == 1) m_state = 2;
            m_ticks = m_ticks - 1;
        end else if (m_state == 2) begin
            if (hit) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_state = 5;
                else begin m_state = 3; m_ticks = P_HF; end
            end else if (bank_level >= P_WIN) m_state = 6;
            else if (pause_sw) m_state = 4;
        end else if (m_state == 4 && !pause_sw) begin
            m_state = 2;
        end
        m_start_q = start_n;
        m_coll_q  = collision;
    endtask

    // One clock: drive at the falling edge, compare, then advance the model at the rising edge.
    task automatic tick(input bit do_check = 1);
        @(negedge clk);
        rst = s_rst; start_n = s_start_n; pause_sw = s_pause;
        collision = s_coll; bank_level = s_bank;
        game_en = (gcnt == 9);
        gcnt = (gcnt + 1) % 10;
        #1;
        if (do_check) begin
            check("state", state, m_state);
            check("lives", lives, m_lives);
            check("sub_rst", sub_rst, m_sub);
            check("flash", flash, model_flash());
            check("play_en", play_en, (game_en && m_state == 2 && !pause_sw) ? 1 : 0);
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        s_start_n = 1'b0; ticks(2);
        s_start_n = 1'b1; tick();
    endtask

    task automatic pulse_coll();
        s_coll = 1'b1; tick();
        s_coll = 1'b0; tick();
    endtask

    task automatic wait_model(input int target, input string tag);
        for (int i = 0; i < 300 && m_state != target; i++) tick();
        #1 check(tag, state, target);
    endtask

    initial begin
        tick(0);
        ticks(3);
        s_rst = 1'b0;
        ticks(3);

        // Start, countdown, first play tick
        press_start();
        wait_model(2, "reach_play");
        #1 check("lives_start", lives, 3);
        ticks(15);

        // Single hit, then a collision held for 100 clocks
        pulse_coll();
        #1 check("lives_hit1", lives, 2);
        wait_model(2, "hit1_recover");
        s_coll = 1'b1; ticks(100);
        s_coll = 1'b0; ticks(3);
        #1 check("lives_held", lives, 1);
        wait_model(2, "held_recover");
        pulse_coll();
        #1 check("go_state", state, 5);
        #1 check("go_flash", flash, 1);
        #1 check("go_lives", lives, 0);
        ticks(5);

        // Restart, then win
        press_start();
        wait_model(2, "replay");
        s_bank = 8'd5; tick();
        #1 check("win_state", state, 6);
        s_bank = 8'd0; ticks(3);

        // Pause with an ignored collision
        press_start();
        wait_model(2, "play_for_pause");
        s_pause = 1'b1; ticks(15);
        pulse_coll();
        #1 check("pause_lives", lives, 3);
        #1 check("pause_state", state, 4);
        s_pause = 1'b0; tick();
        #1 check("unpause_state", state, 2);

        // Hit and win in the same cycle with one life left
        pulse_coll(); wait_model(2, "l2_recover");
        pulse_coll(); wait_model(2, "l1_recover");
        s_coll = 1'b1; s_bank = 8'd7; tick();
        #1 check("hit_beats_win", state, 5);
        s_coll = 1'b0; s_bank = 8'd0; ticks(3);

        // Reset in the middle of a hit freeze
        press_start();
        wait_model(2, "play_for_rst");
        pulse_coll();
        for (int i = 0; i < 300 && !(m_state == 3 && m_ticks == 2); i++) tick();
        s_rst = 1'b1; tick();
        #1 check("rst_state", state, 0);
        #1 check("rst_lives", lives, 3);
        #1 check("rst_flash", flash, 0);
        #1 check("rst_play_en", play_en, 0);
        s_rst = 1'b0; ticks(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            s_rst     = ($urandom_range(0, 499) == 0);
            s_start_n = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 39) == 0) s_pause = ~s_pause;
            if ($urandom_range(0, 7) == 0) s_coll = ~s_coll;
            s_bank = ($urandom_range(0, 59) == 0) ? 8'($urandom_range(5, 255))
                                                   : 8'($urandom_range(0, 4));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
